// File: rtl/nvm_gc_pkg.sv
// Shared GC types and geometry for the block reclaimer and the clean-block FIFO logic.
package nvm_gc_pkg;

    localparam int unsigned BLOCK_W       = 8;
    localparam int unsigned PAGES_PER_BLK = 64;
    localparam int unsigned PAGE_W        = 6;
    localparam int unsigned CNT_W         = PAGE_W + 1;

    typedef logic [BLOCK_W-1:0]       block_t;
    typedef logic [PAGE_W-1:0]        page_t;
    typedef logic [CNT_W-1:0]         cnt_t;
    typedef logic [PAGES_PER_BLK-1:0] map_t;

    typedef enum logic [2:0] {
        GC_IDLE,
        GC_SCAN,
        GC_MOVE,
        GC_ERASE,
        GC_RECOVER
    } gc_state_t;

endpackage

// File: rtl/gc_block_reclaimer_lsb_finder.sv
// Combinational lowest-set-bit priority encoder over the remaining valid-page map.
module lsb_finder #(
    parameter int unsigned PAGES_PER_BLK = 64
) (
    input  logic [PAGES_PER_BLK-1:0]         vec_i,
    output logic [$clog2(PAGES_PER_BLK)-1:0] idx_o,
    output logic                             any_o
);

    localparam int unsigned IDX_W = $clog2(PAGES_PER_BLK);

    // Scan from the top so the lowest set bit is the last to win.
    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
        for (int i = PAGES_PER_BLK - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/gc_block_reclaimer.sv
// Reclaims one victim block: moves its valid pages out in ascending order,
// erases it, then pushes it back to the clean-block FIFO.
module gc_block_reclaimer
    import nvm_gc_pkg::*;
(
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     gc_start,
    input  logic [BLOCK_W-1:0]       victim_blk,
    input  logic [PAGES_PER_BLK-1:0] valid_map,
    input  logic                     host_busy,
    output logic                     move_req,
    output logic [BLOCK_W-1:0]       move_blk,
    output logic [PAGE_W-1:0]        move_page,
    input  logic                     move_done,
    output logic                     erase_req,
    output logic [BLOCK_W-1:0]       erase_blk,
    input  logic                     erase_done,
    output logic                     recover_en,
    output logic [BLOCK_W-1:0]       recover_blk,
    output logic                     busy,
    output logic                     gc_done,
    output logic [CNT_W-1:0]         moved_cnt
);

    gc_state_t state_q;
    block_t    blk_q;
    map_t      map_q;
    logic      move_req_q;
    block_t    move_blk_q;
    page_t     move_page_q;
    logic      erase_req_q;
    block_t    erase_blk_q;
    logic      recover_en_q;
    block_t    recover_blk_q;
    logic      busy_q;
    logic      gc_done_q;
    cnt_t      moved_cnt_q;

    page_t     lsb_idx;
    logic      lsb_any;

    lsb_finder #(
        .PAGES_PER_BLK(PAGES_PER_BLK)
    ) u_lsb_finder (
        .vec_i(map_q),
        .idx_o(lsb_idx),
        .any_o(lsb_any)
    );

    // Reclaim sequencer; every output is a register updated on the transition into its state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= GC_IDLE;
            blk_q         <= '0;
            map_q         <= '0;
            move_req_q    <= 1'b0;
            move_blk_q    <= '0;
            move_page_q   <= '0;
            erase_req_q   <= 1'b0;
            erase_blk_q   <= '0;
            recover_en_q  <= 1'b0;
            recover_blk_q <= '0;
            busy_q        <= 1'b0;
            gc_done_q     <= 1'b0;
            moved_cnt_q   <= '0;
        end else begin
            recover_en_q <= 1'b0;
            gc_done_q    <= 1'b0;
            unique case (state_q)
                GC_IDLE: begin
                    if (gc_start) begin
                        blk_q       <= victim_blk;
                        map_q       <= valid_map;
                        moved_cnt_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= GC_SCAN;
                    end
                end
                GC_SCAN: begin
                    // Erase is never held off by host traffic; only new moves are.
                    if (!lsb_any) begin
                        erase_req_q <= 1'b1;
                        erase_blk_q <= blk_q;
                        state_q     <= GC_ERASE;
                    end else if (!host_busy) begin
                        move_req_q     <= 1'b1;
                        move_blk_q     <= blk_q;
                        move_page_q    <= lsb_idx;
                        map_q[lsb_idx] <= 1'b0;
                        state_q        <= GC_MOVE;
                    end
                end
                GC_MOVE: begin
                    if (move_done) begin
                        move_req_q  <= 1'b0;
                        moved_cnt_q <= moved_cnt_q + CNT_W'(1);
                        state_q     <= GC_SCAN;
                    end
                end
                GC_ERASE: begin
                    if (erase_done) begin
                        erase_req_q   <= 1'b0;
                        recover_en_q  <= 1'b1;
                        gc_done_q     <= 1'b1;
                        recover_blk_q <= blk_q;
                        state_q       <= GC_RECOVER;
                    end
                end
                GC_RECOVER: begin
                    busy_q  <= 1'b0;
                    state_q <= GC_IDLE;
                end
                default: begin
                    state_q <= GC_IDLE;
                end
            endcase
        end
    end

    assign move_req    = move_req_q;
    assign move_blk    = move_blk_q;
    assign move_page   = move_page_q;
    assign erase_req   = erase_req_q;
    assign erase_blk   = erase_blk_q;
    assign recover_en  = recover_en_q;
    assign recover_blk = recover_blk_q;
    assign busy        = busy_q;
    assign gc_done     = gc_done_q;
    assign moved_cnt   = moved_cnt_q;

endmodule

// File: tb/tb_gc_block_reclaimer.sv
// Randomized bench for gc_block_reclaimer: a transaction-level model predicts the
// page order, block addresses, counts and latencies; a bus responder plays the engines.
module tb_gc_block_reclaimer;

    logic        CLK;
    logic        nRST;
    logic        gc_start;
    logic [7:0]  victim_blk;
    logic [63:0] valid_map;
    logic        host_busy;
    logic        move_req;
    logic [7:0]  move_blk;
    logic [5:0]  move_page;
    logic        move_done;
    logic        erase_req;
    logic [7:0]  erase_blk;
    logic        erase_done;
    logic        recover_en;
    logic [7:0]  recover_blk;
    logic        busy;
    logic        gc_done;
    logic [6:0]  moved_cnt;

    gc_block_reclaimer dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .gc_start   (gc_start),
        .victim_blk (victim_blk),
        .valid_map  (valid_map),
        .host_busy  (host_busy),
        .move_req   (move_req),
        .move_blk   (move_blk),
        .move_page  (move_page),
        .move_done  (move_done),
        .erase_req  (erase_req),
        .erase_blk  (erase_blk),
        .erase_done (erase_done),
        .recover_en (recover_en),
        .recover_blk(recover_blk),
        .busy       (busy),
        .gc_done    (gc_done),
        .moved_cnt  (moved_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the pages still owed for the current reclamation, in order.
    int         exp_pages[$];
    logic [7:0] exp_blk    = '0;
    int         exp_total  = 0;
    int         last_total = 0;
    bit         in_gc      = 1'b0;
    bit         recov_seen = 1'b0;
    int         cyc        = 0;
    int         start_cyc  = 0;
    int         first_lat  = -1;
    int         erase_lat  = -1;
    logic [5:0] cur_page   = '0;
    bit         prev_move  = 1'b0;
    bit         prev_erase = 1'b0;
    bit         prev_rec   = 1'b0;

    // Engine responder and host knobs.
    int lat_fix  = -1;
    int er_fix   = -1;
    int mv_lat   = 0;
    int er_lat   = 0;
    int mv_wait  = 0;
    int er_wait  = 0;
    bit md_prev  = 1'b0;
    bit ed_prev  = 1'b0;
    int n_done   = 0;
    bit host_mode  = 1'b1;
    bit host_force = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int pick_lat(input int fix);
        return (fix < 0) ? int'($urandom_range(0, 3)) : fix;
    endfunction

    task automatic set_lat(input int mv, input int er);
        lat_fix = mv;
        er_fix  = er;
        mv_lat  = pick_lat(mv);
        er_lat  = pick_lat(er);
    endtask

    task automatic tick();
        int pg;
        @(negedge CLK);
        cyc++;
        if (nRST) begin
            if (!in_gc) check("cnt_hold", 64'(moved_cnt), 64'(last_total));
            check("busy", 64'(busy), 64'(in_gc));
            check("req_excl", 64'(move_req & erase_req), 64'(0));
            if (move_req && !prev_move) begin
                pg = (exp_pages.size() != 0) ? exp_pages.pop_front() : -1;
                check("move_page", 64'(move_page), 64'(pg));
                check("move_blk", 64'(move_blk), 64'(exp_blk));
                check("move_gate", 64'(host_busy), 64'(0));
                cur_page = move_page;
                if (first_lat < 0) first_lat = cyc - start_cyc;
            end else if (move_req) begin
                check("move_hold", 64'(move_page), 64'(cur_page));
            end
            if (erase_req && !prev_erase) begin
                check("erase_order", 64'(exp_pages.size()), 64'(0));
                check("erase_blk", 64'(erase_blk), 64'(exp_blk));
                erase_lat = cyc - start_cyc;
            end
            if (recover_en) begin
                check("rec_pulse", 64'(prev_rec), 64'(0));
                check("rec_expected", 64'(in_gc), 64'(1));
                check("rec_blk", 64'(recover_blk), 64'(exp_blk));
                check("gc_done", 64'(gc_done), 64'(1));
                check("moved_cnt", 64'(moved_cnt), 64'(exp_total));
                last_total = exp_total;
                in_gc      = 1'b0;
                recov_seen = 1'b1;
            end else begin
                check("gc_done_lo", 64'(gc_done), 64'(0));
            end
        end
        prev_move  = move_req;
        prev_erase = erase_req;
        prev_rec   = recover_en;

        move_done  = 1'b0;
        erase_done = 1'b0;
        if (move_req && !md_prev) begin
            if (mv_wait >= mv_lat) begin
                move_done = 1'b1;
                n_done++;
                mv_wait = 0;
                mv_lat  = pick_lat(lat_fix);
            end else begin
                mv_wait++;
            end
        end
        if (erase_req && !ed_prev) begin
            if (er_wait >= er_lat) begin
                erase_done = 1'b1;
                er_wait = 0;
                er_lat  = pick_lat(er_fix);
            end else begin
                er_wait++;
            end
        end
        md_prev   = move_done;
        ed_prev   = erase_done;
        host_busy = host_mode ? host_force : ($urandom_range(0, 3) == 0);
    endtask

    task automatic start_gc(input logic [7:0] blk, input logic [63:0] map);
        exp_pages.delete();
        for (int i = 0; i < 64; i++) begin
            if (map[i]) exp_pages.push_back(i);
        end
        exp_blk    = blk;
        exp_total  = exp_pages.size();
        in_gc      = 1'b1;
        recov_seen = 1'b0;
        first_lat  = -1;
        erase_lat  = -1;
        start_cyc  = cyc;
        gc_start   = 1'b1;
        victim_blk = blk;
        valid_map  = map;
        tick();
        gc_start   = 1'b0;
    endtask

    task automatic run_to_recover(input int budget);
        for (int i = 0; i < budget && !recov_seen; i++) tick();
        check("recover_in_budget", 64'(recov_seen), 64'(1));
        tick();
    endtask

    task automatic wait_move_req();
        for (int i = 0; i < 50 && !move_req; i++) tick();
        check("move_req_seen", 64'(move_req), 64'(1));
    endtask

    task automatic model_reset();
        exp_pages.delete();
        in_gc      = 1'b0;
        last_total = 0;
        mv_wait    = 0;
        er_wait    = 0;
        md_prev    = 1'b0;
        ed_prev    = 1'b0;
        prev_move  = 1'b0;
        prev_erase = 1'b0;
        prev_rec   = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] map;
        int          base;
        nRST       = 1'b0;
        gc_start   = 1'b0;
        victim_blk = '0;
        valid_map  = '0;
        host_busy  = 1'b0;
        move_done  = 1'b0;
        erase_done = 1'b0;
        set_lat(0, 0);
        tick();
        tick();
        check("reset_outs", 64'({move_req, erase_req, recover_en, gc_done, busy, moved_cnt,
                                 move_blk, move_page, erase_blk, recover_blk}), 64'(0));
        nRST = 1'b1;
        tick();

        // Basic reclaim: pages 0, 5, 63 of block 0x2A.
        map = '0;
        map[0] = 1'b1; map[5] = 1'b1; map[63] = 1'b1;
        start_gc(8'h2A, map);
        run_to_recover(200);
        check("first_move_lat", 64'(first_lat), 64'(2));
        check("basic_cnt", 64'(moved_cnt), 64'(3));

        // Empty map goes straight to erase.
        start_gc(8'h5C, 64'd0);
        run_to_recover(50);
        check("empty_erase_lat", 64'(erase_lat), 64'(2));
        check("empty_no_move", 64'(first_lat), 64'(-1));

        // Full map with a one-cycle engine.
        set_lat(1, 1);
        start_gc(8'hC3, '1);
        run_to_recover(1000);
        check("full_cnt", 64'(moved_cnt), 64'(64));

        // Host pause after the first move, then host busy across the last move and erase.
        set_lat(2, 2);
        map = '0;
        map[3] = 1'b1; map[9] = 1'b1;
        start_gc(8'h7E, map);
        base = n_done;
        for (int i = 0; i < 20 && n_done == base; i++) tick();
        host_force = 1'b1;
        host_busy  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("pause_move_lo", 64'(move_req), 64'(0));
        end
        host_force = 1'b0;
        host_busy  = 1'b0;
        tick();
        check("resume_move", 64'(move_req), 64'(1));
        host_force = 1'b1;
        host_busy  = 1'b1;
        run_to_recover(50);
        host_force = 1'b0;
        host_busy  = 1'b0;

        // Start and stray erase_done during MOVE are ignored.
        set_lat(3, 1);
        map = '0;
        map[1] = 1'b1; map[2] = 1'b1;
        start_gc(8'h2A, map);
        wait_move_req();
        gc_start   = 1'b1;
        victim_blk = 8'h11;
        valid_map  = '1;
        erase_done = 1'b1;
        tick();
        gc_start   = 1'b0;
        check("ign_move_req", 64'(move_req), 64'(1));
        check("ign_erase_req", 64'(erase_req), 64'(0));
        run_to_recover(100);
        check("ign_rec_blk", 64'(recover_blk), 64'(8'h2A));

        // Reset while erasing aborts with no recover.
        set_lat(0, 20);
        map = '0;
        map[2] = 1'b1;
        start_gc(8'h33, map);
        for (int i = 0; i < 50 && !erase_req; i++) tick();
        check("erase_seen", 64'(erase_req), 64'(1));
        nRST = 1'b0;
        #1;
        check("midop_reset_outs", 64'({move_req, erase_req, recover_en, gc_done, busy, moved_cnt,
                                       move_blk, move_page, erase_blk, recover_blk}), 64'(0));
        model_reset();
        tick();
        tick();
        nRST = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        set_lat(-1, -1);
        start_gc(8'h44, 64'h0000_00F0_0000_0101);
        run_to_recover(200);

        // Randomized reclamations with random latency and host traffic.
        host_mode = 1'b0;
        for (int r = 0; r < 24; r++) begin
            map = {$urandom, $urandom};
            case (r % 4)
                0: map = map & {$urandom, $urandom};
                1: map = map & {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                2: map = map | {$urandom, $urandom};
                default: begin
                    map = '0;
                    if ($urandom_range(0, 1) == 1) map[$urandom_range(0, 63)] = 1'b1;
                end
            endcase
            start_gc(8'($urandom), map);
            run_to_recover(2000);
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gc_block_reclaimer.md
Name: gc_block_reclaimer

Overview:
- Sequences reclamation of one victim block for garbage collection.
- Copies out every valid page of the victim, one move at a time, then erases the block.
- Hands the erased block back to the clean-block FIFO through a one-cycle recover strobe.
- Sits between the GC controller (start, victim select) and the flash move/erase engines; pauses between page moves while the host is active.

Parameters:
- BLOCK_W, 8, block address width.
- PAGES_PER_BLK, 64, pages per block; width of the valid bitmap.
- PAGE_W, 6, page index width; must equal clog2(PAGES_PER_BLK).

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- gc_start  in  1  start request, sampled only in IDLE.
- victim_blk  in  BLOCK_W  victim block, latched on accepted gc_start.
- valid_map  in  PAGES_PER_BLK  valid-page bitmap of victim, latched on accepted gc_start.
- host_busy  in  1  when high, no new move is issued.
- move_req  out  1  page-move request, held until move_done.
- move_blk  out  BLOCK_W  source block of the move.
- move_page  out  PAGE_W  source page of the move.
- move_done  in  1  one-cycle completion from the move engine.
- erase_req  out  1  erase request, held until erase_done.
- erase_blk  out  BLOCK_W  block to erase.
- erase_done  in  1  one-cycle completion from the erase engine.
- recover_en  out  1  one-cycle push of the reclaimed block to the clean FIFO.
- recover_blk  out  BLOCK_W  reclaimed block, valid while recover_en is high.
- busy  out  1  high in every state except IDLE.
- gc_done  out  1  one-cycle pulse, coincident with recover_en.
- moved_cnt  out  PAGE_W+1  pages moved in the current or last reclamation.

Behaviour:
- Clock and reset: single clock CLK; reset nRST is asynchronous and active-low.
- Reset values: state=IDLE; all outputs 0; blk_r=0; map_r=0; moved_cnt=0.
- Reset mid-operation: aborts immediately to IDLE; no recover_en is issued; any outstanding move or erase is abandoned (the requesters also reset).
- FSM states: IDLE, SCAN, MOVE, ERASE, RECOVER.
- IDLE:
  - On gc_start: latch blk_r<=victim_blk and map_r<=valid_map; clear moved_cnt; go to SCAN the next cycle.
- SCAN (lowest set bit idx of map_r):
  - If map_r==0: go to ERASE.
  - Else if host_busy: stay in SCAN.
  - Else: register move_page<=idx, clear map_r[idx], go to MOVE.
- MOVE:
  - move_req=1; move_blk=blk_r; move_page is stable for the whole state.
  - On move_done: moved_cnt+=1, return to SCAN.
  - Gap between consecutive move requests: move_req low for at least one cycle (the SCAN cycle).
- ERASE:
  - erase_req=1; erase_blk=blk_r.
  - On erase_done: go to RECOVER.
- RECOVER:
  - recover_en=1, recover_blk=blk_r, gc_done=1 for exactly one cycle, then IDLE.
- Ignored inputs:
  - gc_start outside IDLE is ignored and not queued.
  - move_done outside MOVE and erase_done outside ERASE are ignored.
- Latency:
  - gc_start to first move_req = 2 cycles (IDLE->SCAN->MOVE).
  - gc_start with an all-zero map to erase_req = 2 cycles.
- Ordering and counts:
  - Pages are moved in ascending index order.
  - moved_cnt reaches PAGES_PER_BLK for a full map; width PAGE_W+1 prevents wrap.
  - moved_cnt holds its value in IDLE until the next accepted start.
- host_busy rules:
  - host_busy never aborts a move already in MOVE; it only blocks the SCAN->MOVE transition.
  - host_busy does not block ERASE.
- move_done arriving in the same cycle MOVE is entered counts (the engine may complete combinationally).

Decomposition:
- Package nvm_gc_pkg: block_t (logic [BLOCK_W-1:0]), page_t (logic [PAGE_W-1:0]), the GC state enum, BLOCK_W/PAGE_W/PAGES_PER_BLK constants, shared with the clean-block FIFO logic.
- Sub-module lsb_finder (parameterised by PAGES_PER_BLK): combinational lowest-set-bit priority encoder producing idx and any. The FSM and counters stay in gc_block_reclaimer.

Test Plan:
- Basic reclaim: victim_blk=0x2A, valid_map bits {0,5,63} -> move_page sequence 0,5,63 with move_blk=0x2A; after the third move_done, erase_req with erase_blk=0x2A; after erase_done, one-cycle recover_en/gc_done with recover_blk=0x2A; moved_cnt=3.
- Empty map: valid_map=0 -> no move_req; erase_req 2 cycles after gc_start; moved_cnt=0.
- Full map: valid_map all ones, move_done 1 cycle after each request -> 64 moves, pages 0..63 in order; moved_cnt=64; no wrap.
- Host pause: host_busy high for 10 cycles after the first move_done -> move_req stays low for those 10 cycles; the next move is issued the cycle after host_busy falls; a move in flight still completes.
- Busy/ignore: second gc_start with victim 0x11 during MOVE -> ignored; stray erase_done during MOVE -> no state change; recover_blk remains the first victim.
- Reset mid-op: assert nRST low in ERASE -> all outputs 0 immediately; no recover_en after release; a new gc_start is accepted normally.
